// File: rtl/command_fetcher_pkg.sv
// Shared definitions for the command fetcher: bus widths, command opcodes
// and the fetcher state encoding.
package command_fetcher_pkg;

  localparam int MAIN_MEMORY_BUS_ADDR_WIDTH = 32;
  localparam int MAIN_MEMORY_BUS_DEPTH      = 32;
  localparam int COMMAND_BUFFER_DEPTH       = 64;

  // Opcodes carried in bits [31:16] of a command word.
  typedef enum logic [15:0] {
    COMMAND_OP_NOP     = 16'h0000,
    COMMAND_OP_DRAW    = 16'h0001,
    COMMAND_OP_SET_REG = 16'h0002,
    COMMAND_OP_JUMP    = 16'h0003,
    COMMAND_OP_END     = 16'hFFFF
  } command_operands_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } fetch_state_e;

  // Opcode field of a 32-bit command word.
  function automatic logic [15:0] command_opcode(input logic [31:0] word);
    return word[31:16];
  endfunction

  // Operand field of a 32-bit command word.
  function automatic logic [15:0] command_operand(input logic [31:0] word);
    return word[15:0];
  endfunction

endpackage

// File: rtl/command_fetcher_command_buffer.sv
// Command buffer: BUFFER_DEPTH x DATA_WIDTH register array, one synchronous
// write port, one combinational read port, asynchronous clear of every entry.
module command_buffer
  import command_fetcher_pkg::*;
#(
  parameter int DATA_WIDTH   = MAIN_MEMORY_BUS_DEPTH,
  parameter int BUFFER_DEPTH = COMMAND_BUFFER_DEPTH,
  localparam int IDX_W       = $clog2(BUFFER_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] entries [BUFFER_DEPTH];

  for (genvar gi = 0; gi < BUFFER_DEPTH; gi++) begin : g_entry
    logic [DATA_WIDTH-1:0] entry_d;
    logic [DATA_WIDTH-1:0] entry_q;

    // Load this entry when the write port addresses it.
    always_comb begin
      entry_d = entry_q;
      if (wr_en && (wr_idx == IDX_W'(gi))) begin
        entry_d = wr_data;
      end
    end

    // Entry storage, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign entries[gi] = entry_q;
  end

  // Read sees the registered value, so a same-cycle write is not bypassed.
  assign rd_data = entries[rd_idx];

endmodule

// File: rtl/command_fetcher.sv
// Command fetcher: on execute, streams BUFFER_DEPTH consecutive words from a
// 1-cycle-latency memory into the command buffer, then raises ready.
module command_fetcher
  import command_fetcher_pkg::*;
#(
  parameter int ADDR_WIDTH   = MAIN_MEMORY_BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH   = MAIN_MEMORY_BUS_DEPTH,
  parameter int BUFFER_DEPTH = COMMAND_BUFFER_DEPTH,
  localparam int IDX_W       = $clog2(BUFFER_DEPTH)
) (
  input  logic                  aClock,
  input  logic                  aReset,
  input  logic [ADDR_WIDTH-1:0] aCommandPointer,
  input  logic                  anExecute,
  output logic [ADDR_WIDTH-1:0] anOutMemoryAddr,
  input  logic [DATA_WIDTH-1:0] aMemoryData,
  output logic                  anOutMemoryEnable,
  input  logic [IDX_W-1:0]      aCommandIndex,
  output logic [DATA_WIDTH-1:0] aCommandData,
  input  logic                  aCommandRead,
  output logic                  anOutReady
);

  localparam int              CNT_W     = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUFFER_DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BUFFER_DEPTH - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  enable_q, enable_d;
  logic                  ready_q, ready_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      cap_cnt_q, cap_cnt_d;

  logic issue_more;
  logic capture_en;
  logic last_capture;

  // The consumer read strobe is reserved and deliberately has no effect.
  logic unused_command_read;
  assign unused_command_read = aCommandRead;

  // issue_cnt counts reads already issued; rd_valid marks that aMemoryData
  // carries the word for the read issued one cycle earlier.
  assign issue_more   = issue_cnt_q < DEPTH_CNT;
  assign capture_en   = (state_q == FETCH) && rd_valid_q;
  assign last_capture = capture_en && (cap_cnt_q == LAST_CNT);

  // State register.
  always_ff @(posedge aClock or negedge aReset) begin
    if (!aReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: execute is only honoured outside FETCH.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, READY: if (anExecute) state_d = FETCH;
      FETCH:       if (last_capture) state_d = READY;
      default:     state_d = IDLE;
    endcase
  end

  // Next values for the memory interface, counters and ready flag.
  always_comb begin
    base_d      = base_q;
    addr_d      = addr_q;
    enable_d    = 1'b0;
    ready_d     = ready_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    rd_valid_d  = enable_q;
    unique case (state_q)
      IDLE, READY: begin
        if (anExecute) begin
          // First read goes out in the cycle right after the sampling edge.
          base_d      = aCommandPointer;
          addr_d      = aCommandPointer;
          enable_d    = 1'b1;
          ready_d     = 1'b0;
          issue_cnt_d = CNT_W'(1);
          cap_cnt_d   = '0;
        end
      end
      FETCH: begin
        if (issue_more) begin
          enable_d    = 1'b1;
          addr_d      = base_q + ADDR_WIDTH'(issue_cnt_q);
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (capture_en) begin
          cap_cnt_d = cap_cnt_q + 1'b1;
        end
        if (last_capture) begin
          ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and counters.
  always_ff @(posedge aClock or negedge aReset) begin
    if (!aReset) begin
      base_q      <= '0;
      addr_q      <= '0;
      enable_q    <= 1'b0;
      ready_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
    end else begin
      base_q      <= base_d;
      addr_q      <= addr_d;
      enable_q    <= enable_d;
      ready_q     <= ready_d;
      rd_valid_q  <= rd_valid_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
    end
  end

  command_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BUFFER_DEPTH(BUFFER_DEPTH)
  ) u_command_buffer (
    .clk    (aClock),
    .rst_n  (aReset),
    .wr_en  (capture_en),
    .wr_idx (cap_cnt_q[IDX_W-1:0]),
    .wr_data(aMemoryData),
    .rd_idx (aCommandIndex),
    .rd_data(aCommandData)
  );

  assign anOutMemoryAddr   = addr_q;
  assign anOutMemoryEnable = enable_q;
  assign anOutReady        = ready_q;

endmodule

// File: tb/tb_command_fetcher.sv
// Testbench for command_fetcher: memory model plus list-level reference model.
module tb_command_fetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ptr = 32'h0;
  logic        exec = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = 32'h0;
  logic        mem_en;
  logic [5:0]  idx = 6'd0;
  logic [31:0] cmd_data;
  logic        cmd_read = 1'b0;
  logic        ready;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] salt = 32'h0;
  logic [31:0] model_buf [64];

  always #5 clk = ~clk;

  command_fetcher dut (
    .aClock           (clk),
    .aReset           (rst_n),
    .aCommandPointer  (ptr),
    .anExecute        (exec),
    .anOutMemoryAddr  (mem_addr),
    .aMemoryData      (mem_data),
    .anOutMemoryEnable(mem_en),
    .aCommandIndex    (idx),
    .aCommandData     (cmd_data),
    .aCommandRead     (cmd_read),
    .anOutReady       (ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (32'hA500_0000 | a) ^ salt;
  endfunction

  // Synchronous memory, 1-cycle latency; garbage when not enabled.
  always @(posedge clk) begin
    if (mem_en) mem_data <= mem_word(mem_addr);
    else        mem_data <= $urandom;
  end

  // Reserved read strobe toggles randomly all the time.
  always @(negedge clk) cmd_read = 1'($urandom_range(0, 1));

  task automatic check_buffer(input string tag);
    for (int i = 0; i < 64; i++) begin
      idx = 6'(i);
      #1;
      checks++;
      if (cmd_data !== model_buf[i]) begin
        errors++;
        $display("FAIL %s buf[%0d]: got %h expected %h", tag, i, cmd_data, model_buf[i]);
      end
    end
  endtask

  // Present a pointer and raise execute; returns at the negedge of cycle 0.
  task automatic start_exec(input logic [31:0] p);
    @(negedge clk);
    ptr  = p;
    exec = 1'b1;
    @(negedge clk);
  endtask

  // Walks cycles 0..65 of a fetch from base, checking strobe, address, ready
  // and partial buffer contents. mid_k >= 0 injects an ignored execute.
  task automatic run_fetch(input logic [31:0] base, input int mid_k, input logic hold, input string tag);
    logic [31:0] newv [64];
    logic        exp_en, exp_rdy;
    for (int i = 0; i < 64; i++) newv[i] = mem_word(base + 32'(i));
    for (int k = 0; k <= 65; k++) begin
      if (k > 0) @(negedge clk);
      if (!hold) exec = 1'b0;
      if (k == mid_k) begin
        exec = 1'b1;
        ptr  = 32'h300;
      end
      #1;
      exp_en  = (k < 64);
      exp_rdy = (k == 65);
      checks++;
      if (mem_en !== exp_en || ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s cycle %0d en/ready: got %b/%b expected %b/%b", tag, k, mem_en, ready, exp_en, exp_rdy);
      end
      if (k < 64) begin
        checks++;
        if (mem_addr !== base + 32'(k)) begin
          errors++;
          $display("FAIL %s cycle %0d addr: got %h expected %h", tag, k, mem_addr, base + 32'(k));
        end
      end
      if (k == 10) begin
        // Entries 0..8 captured by now; entry 9 still holds the old list.
        idx = 6'd8;
        #1;
        checks++;
        if (cmd_data !== newv[8]) begin
          errors++;
          $display("FAIL %s partial buf[8]: got %h expected %h", tag, cmd_data, newv[8]);
        end
        idx = 6'd9;
        #1;
        checks++;
        if (cmd_data !== model_buf[9]) begin
          errors++;
          $display("FAIL %s partial buf[9]: got %h expected %h", tag, cmd_data, model_buf[9]);
        end
      end
    end
    for (int i = 0; i < 64; i++) model_buf[i] = newv[i];
    if (hold) @(negedge clk);
    else      check_buffer(tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) model_buf[i] = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (mem_en !== 1'b0) begin errors++; $display("FAIL reset enable: got %b expected 0", mem_en); end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset ready: got %b expected 0", ready); end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset addr: got %h expected 0", mem_addr); end
    idx = 6'd0;
    #1;
    checks++;
    if (cmd_data !== 32'h0) begin errors++; $display("FAIL reset buf[0]: got %h expected 0", cmd_data); end
    idx = 6'd63;
    #1;
    checks++;
    if (cmd_data !== 32'h0) begin errors++; $display("FAIL reset buf[63]: got %h expected 0", cmd_data); end
  endtask

  task automatic test_fetch();
    salt = 32'h0;
    start_exec(32'h100);
    run_fetch(32'h100, -1, 1'b0, "fetch");
    idx = 6'd5;
    #1;
    checks++;
    if (cmd_data !== 32'hA500_0105) begin errors++; $display("FAIL fetch idx5: got %h expected a5000105", cmd_data); end
    idx = 6'd63;
    #1;
    checks++;
    if (cmd_data !== 32'hA500_013F) begin errors++; $display("FAIL fetch idx63: got %h expected a500013f", cmd_data); end
  endtask

  task automatic test_refetch_from_ready();
    start_exec(32'h200);
    run_fetch(32'h200, -1, 1'b0, "refetch");
  endtask

  task automatic test_ignore_exec_midfetch();
    start_exec(32'h100);
    run_fetch(32'h100, 20, 1'b0, "midexec");
  endtask

  task automatic test_reset_midfetch();
    start_exec(32'h100);
    exec = 1'b0;
    idx  = 6'd0;
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0 || ready !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL async reset outputs: en %b ready %b addr %h expected 0 0 0", mem_en, ready, mem_addr);
    end
    checks++;
    if (cmd_data !== 32'h0) begin errors++; $display("FAIL async reset buf[0]: got %h expected 0", cmd_data); end
    for (int i = 0; i < 64; i++) model_buf[i] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    start_exec(32'h100);
    run_fetch(32'h100, -1, 1'b0, "restart");
  endtask

  task automatic test_wrap();
    salt = 32'h0;
    start_exec(32'hFFFF_FFFE);
    run_fetch(32'hFFFF_FFFE, -1, 1'b0, "wrap");
  endtask

  task automatic test_back_to_back();
    salt = $urandom;
    start_exec(32'h400);
    ptr = 32'h500;  // only sampled once READY is reached
    run_fetch(32'h400, -1, 1'b1, "b2b_first");
    run_fetch(32'h500, -1, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    logic [31:0] p;
    int          mk;
    for (int r = 0; r < 3; r++) begin
      salt = $urandom;
      p    = $urandom;
      mk   = int'($urandom_range(1, 60));
      start_exec(p);
      run_fetch(p, mk, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_refetch_from_ready();
    test_ignore_exec_midfetch();
    test_reset_midfetch();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
